// File: rtl/jam_cost_table_if.sv
// -----------------------------------------------------------------------------
// jam_cost_table_if
//
// Bundles every non-clock signal of the JAM cost-table responder.
//
// Host load stream (valid/ready):
//   in_valid  - host offers a cost word in in_data.
//   in_ready  - block takes a word this cycle.
//   in_data   - 7-bit cost word, row-major order (entry = W*8+J).
//   restart   - single-cycle request to reload the table and rerun.
//   A word is transferred on a rising edge where in_valid && in_ready are both
//   high and restart is low. in_data must be stable while in_valid is high.
//   The block never withdraws in_ready mid-load.
//
// Solver side:
//   W, J          - lookup indices from the solver.
//   Cost          - combinational cost of (W, J).
//   JAM_RST       - reset to the solver core.
//   JamMinCost    - solver result MinCost.
//   JamMatchCount - solver result MatchCount.
//   JamValid      - solver result valid (level).
//
// Results / status:
//   ResMinCost, ResMatchCount, ResValid - captured solver result.
//   AccessCnt - cycles spent in RUN (zero unless the counter is built in).
//   dbg_state - current controller state (LOAD=0, RUN=1, DONE=2).
//
// Modports: slave = the cost table, master = host/solver/testbench side.
// -----------------------------------------------------------------------------
interface jam_cost_table_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_data;
    logic        restart;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic        JAM_RST;
    logic [9:0]  JamMinCost;
    logic [3:0]  JamMatchCount;
    logic        JamValid;
    logic [9:0]  ResMinCost;
    logic [3:0]  ResMatchCount;
    logic        ResValid;
    logic [19:0] AccessCnt;
    logic [1:0]  dbg_state;

    modport slave (
        input  in_valid, in_data, restart, W, J,
               JamMinCost, JamMatchCount, JamValid,
        output in_ready, Cost, JAM_RST, ResMinCost, ResMatchCount,
               ResValid, AccessCnt, dbg_state
    );

    modport master (
        output in_valid, in_data, restart, W, J,
               JamMinCost, JamMatchCount, JamValid,
        input  in_ready, Cost, JAM_RST, ResMinCost, ResMatchCount,
               ResValid, AccessCnt, dbg_state
    );
endinterface

// File: rtl/jam_cost_table.sv
// -----------------------------------------------------------------------------
// jam_cost_table
//
// Cost-table responder for the JAM job-assignment solver. Loads a 64-entry
// (8 workers x 8 jobs) table of 7-bit costs from a host stream, holds the
// solver in reset until the table is complete, answers (W, J) lookups
// combinationally and captures the solver's final MinCost/MatchCount.
//
// Ports:
//   CLK  - system clock, all state updates on the rising edge.
//   RST  - synchronous, active-high reset (clears the table too).
//   bus  - jam_cost_table_if.slave: host load stream, solver lookup and
//          result signals, captured results, access counter, debug state.
//
// Optional feature (macro JAM_COST_ACCESS_CNT_EN):
//   defined   - AccessCnt counts edges spent in RUN (including the capture
//               edge), saturates at 20'hFFFFF, freezes in DONE and clears
//               whenever LOAD is entered.
//   undefined - AccessCnt is tied to zero and no counter is built.
//
// States:
//   LOAD - accepting words, solver held in reset.
//   RUN  - solver running, waiting for JamValid.
//   DONE - result held until restart.
// -----------------------------------------------------------------------------
module jam_cost_table (
    input  logic              CLK,
    input  logic              RST,
    jam_cost_table_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q;
    state_e      state_d;

    logic [6:0]  mem_q [64];
    logic [5:0]  wr_ptr_q;
    logic [5:0]  wr_ptr_d;
    logic        wr_en;

    logic [9:0]  res_min_q;
    logic [9:0]  res_min_d;
    logic [3:0]  res_cnt_q;
    logic [3:0]  res_cnt_d;
    logic        res_valid_q;
    logic        res_valid_d;

    // -------------------------------------------------------------------------
    // Next-state and control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_en       = 1'b0;
        res_min_d   = res_min_q;
        res_cnt_d   = res_cnt_q;
        res_valid_d = res_valid_q;

        case (state_q)
            ST_LOAD: begin
                // restart rewinds the pointer and suppresses any write that
                // cycle, even when a word is offered.
                if (bus.restart) begin
                    wr_ptr_d = '0;
                end else if (bus.in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 6'd1;  // wraps to 0 after entry 63
                    if (wr_ptr_q == 6'd63) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // restart beats a simultaneous JamValid: no capture.
                if (bus.restart) begin
                    state_d     = ST_LOAD;
                    wr_ptr_d    = '0;
                    res_valid_d = 1'b0;
                end else if (bus.JamValid) begin
                    res_min_d   = bus.JamMinCost;
                    res_cnt_d   = bus.JamMatchCount;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                // Result is held; JamValid no longer matters.
                if (bus.restart) begin
                    state_d     = ST_LOAD;
                    wr_ptr_d    = '0;
                    res_valid_d = 1'b0;
                end
            end

            default: begin
                state_d  = ST_LOAD;
                wr_ptr_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= '0;
            res_min_q   <= '0;
            res_cnt_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            res_min_q   <= res_min_d;
            res_cnt_q   <= res_cnt_d;
            res_valid_q <= res_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Cost table. Cleared only by RST; a restart reload simply overwrites it.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Optional RUN-cycle counter
    // -------------------------------------------------------------------------
`ifdef JAM_COST_ACCESS_CNT_EN
    logic [19:0] acc_q;
    logic [19:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (state_q != ST_LOAD && state_d == ST_LOAD) begin
            acc_d = '0;
        end else if (state_q == ST_RUN && acc_q != 20'hFFFFF) begin
            acc_d = acc_q + 20'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign bus.AccessCnt = acc_q;
`else
    assign bus.AccessCnt = '0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.in_ready      = (state_q == ST_LOAD);
    // Combinational so the solver comes out of reset on the first edge after
    // RUN is entered.
    assign bus.JAM_RST       = RST | (state_q == ST_LOAD);
    assign bus.Cost          = mem_q[{bus.W, bus.J}];
    assign bus.ResMinCost    = res_min_q;
    assign bus.ResMatchCount = res_cnt_q;
    assign bus.ResValid      = res_valid_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_jam_cost_table.sv
module tb_jam_cost_table;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    jam_cost_table_if bus ();

    jam_cost_table dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

`ifdef JAM_COST_ACCESS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------------
    // Reference model: the table as an array, the current load pass as a
    // queue of accepted words, and the run/result status as plain flags.
    // ------------------------------------------------------------------------
    logic [6:0] m_mem [64];
    logic [6:0] exp_q [$];
    bit         m_loading   = 1'b1;
    bit         m_res_valid = 1'b0;
    logic [9:0] m_min       = '0;
    logic [3:0] m_mc        = '0;
    int         m_run       = 0;

    task automatic model_edge();
        if (RST) begin
            for (int i = 0; i < 64; i++) m_mem[i] = '0;
            exp_q.delete();
            m_loading   = 1'b1;
            m_res_valid = 1'b0;
            m_min       = '0;
            m_mc        = '0;
            m_run       = 0;
        end else if (m_loading) begin
            if (bus.restart) begin
                exp_q.delete();
            end else if (bus.in_valid) begin
                m_mem[6'(exp_q.size())] = bus.in_data;
                exp_q.push_back(bus.in_data);
                if (exp_q.size() == 64) begin
                    exp_q.delete();
                    m_loading = 1'b0;
                end
            end
        end else if (bus.restart) begin
            m_loading   = 1'b1;
            m_res_valid = 1'b0;
            m_run       = 0;
        end else if (!m_res_valid) begin
            // Solver running until a result is held.
            if (m_run < 32'h000F_FFFF) m_run++;
            if (bus.JamValid) begin
                m_res_valid = 1'b1;
                m_min       = bus.JamMinCost;
                m_mc        = bus.JamMatchCount;
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Driver / checker tasks
    // ------------------------------------------------------------------------
    task automatic clk_edge();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},      32'(bus.in_ready),      32'(m_loading));
        chk({tag, ".jam_rst"},       32'(bus.JAM_RST),       32'(RST | m_loading));
        chk({tag, ".res_valid"},     32'(bus.ResValid),      32'(m_res_valid));
        chk({tag, ".res_min"},       32'(bus.ResMinCost),    32'(m_min));
        chk({tag, ".res_mc"},        32'(bus.ResMatchCount), 32'(m_mc));
        chk({tag, ".access_cnt"},    32'(bus.AccessCnt),     CNT_EN ? 32'(m_run) : 32'd0);
        chk({tag, ".cost"},          32'(bus.Cost),          32'(m_mem[{bus.W, bus.J}]));
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 64; i++) begin
            bus.W = 3'(i >> 3);
            bus.J = 3'(i & 7);
            #1;
            chk({tag, ".cost"}, 32'(bus.Cost), 32'(m_mem[6'(i)]));
            if ((i % 4) == 3) clk_edge();
        end
    endtask

    task automatic load_word(input logic [6:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        clk_edge();
        bus.in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Lookup vectors after the (k+1)%128 load
    // ------------------------------------------------------------------------
    typedef struct {
        string      name;
        logic [2:0] w;
        logic [2:0] j;
        logic [6:0] cost;
    } lk_t;

    lk_t tbl [6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        tbl[0] = '{"w3j5", 3'd3, 3'd5, 7'd30};
        tbl[1] = '{"w7j7", 3'd7, 3'd7, 7'd64};
        tbl[2] = '{"w0j0", 3'd0, 3'd0, 7'd1};
        tbl[3] = '{"w0j7", 3'd0, 3'd7, 7'd8};
        tbl[4] = '{"w4j0", 3'd4, 3'd0, 7'd33};
        tbl[5] = '{"w7j6", 3'd7, 3'd6, 7'd63};

        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.restart       = 1'b0;
        bus.W             = '0;
        bus.J             = '0;
        bus.JamMinCost    = '0;
        bus.JamMatchCount = '0;
        bus.JamValid      = 1'b0;

        // Reset
        RST = 1'b1;
        clk_edge();
        clk_edge();
        RST = 1'b0;
        #1;
        chk("rst.in_ready",   32'(bus.in_ready),   32'd1);
        chk("rst.jam_rst",    32'(bus.JAM_RST),    32'd1);
        chk("rst.res_valid",  32'(bus.ResValid),   32'd0);
        chk("rst.access_cnt", 32'(bus.AccessCnt),  32'd0);
        chk("rst.res_min",    32'(bus.ResMinCost), 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.W = 3'($urandom_range(0, 7));
            bus.J = 3'($urandom_range(0, 7));
            #1;
            chk("rst.cost", 32'(bus.Cost), 32'd0);
        end

        // Load (k+1)%128 with a 3-cycle gap after k=20
        for (int k = 0; k < 64; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'((k + 1) % 128);
            if (k == 63) begin
                #1;
                chk("load.ready_before_last", 32'(bus.in_ready), 32'd1);
                chk("load.jamrst_before_last", 32'(bus.JAM_RST), 32'd1);
            end
            clk_edge();
            if (k == 20) begin
                bus.in_valid = 1'b0;
                repeat (3) clk_edge();
            end
        end
        bus.in_valid = 1'b0;
        chk("load.in_ready", 32'(bus.in_ready), 32'd0);
        chk("load.jam_rst",  32'(bus.JAM_RST),  32'd0);

        for (int t = 0; t < 6; t++) begin
            bus.W = tbl[t].w;
            bus.J = tbl[t].j;
            #1;
            chk({"lut.", tbl[t].name}, 32'(bus.Cost), 32'(tbl[t].cost));
        end
        check_table("lut");

        // Writes outside LOAD are ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h7F;
        repeat (10) clk_edge();
        bus.in_valid = 1'b0;
        bus.W = 3'd0;
        bus.J = 3'd0;
        #1;
        chk("ignore.cost00", 32'(bus.Cost), 32'd1);
        check_all("ignore");
        check_table("ignore");

        // Capture
        bus.JamMinCost    = 10'd123;
        bus.JamMatchCount = 4'd2;
        bus.JamValid      = 1'b1;
        clk_edge();
        chk("cap.res_valid", 32'(bus.ResValid),      32'd1);
        chk("cap.res_min",   32'(bus.ResMinCost),    32'd123);
        chk("cap.res_mc",    32'(bus.ResMatchCount), 32'd2);
        check_all("cap");
        bus.JamMinCost    = 10'd500;
        bus.JamMatchCount = 4'd9;
        repeat (3) clk_edge();
        chk("cap.hold_min", 32'(bus.ResMinCost),    32'd123);
        chk("cap.hold_mc",  32'(bus.ResMatchCount), 32'd2);
        check_all("cap.hold");

        // Restart from DONE
        bus.restart = 1'b1;
        clk_edge();
        bus.restart = 1'b0;
        chk("rst_done.in_ready",  32'(bus.in_ready),   32'd1);
        chk("rst_done.jam_rst",   32'(bus.JAM_RST),    32'd1);
        chk("rst_done.res_valid", 32'(bus.ResValid),   32'd0);
        chk("rst_done.res_min",   32'(bus.ResMinCost), 32'd123);
        check_all("rst_done");
        bus.JamValid = 1'b0;

        // Reload with 9, with a restart in LOAD after 10 words
        for (int k = 0; k < 10; k++) load_word(7'd9);
        bus.restart  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h55;
        clk_edge();
        bus.restart  = 1'b0;
        bus.in_valid = 1'b0;
        bus.W = 3'd1;
        bus.J = 3'd2;
        #1;
        chk("rld.no_write", 32'(bus.Cost), 32'd11);
        check_all("rld");
        for (int k = 0; k < 63; k++) load_word(7'd9);
        chk("rld.still_loading", 32'(bus.in_ready), 32'd1);
        load_word(7'd9);
        chk("rld.in_ready", 32'(bus.in_ready), 32'd0);
        bus.W = 3'd2;
        bus.J = 3'd4;
        #1;
        chk("rld.w2j4", 32'(bus.Cost), 32'd9);
        check_table("rld");

        // restart together with JamValid in RUN
        bus.JamMinCost    = 10'd77;
        bus.JamMatchCount = 4'd5;
        bus.JamValid      = 1'b1;
        bus.restart       = 1'b1;
        clk_edge();
        bus.restart  = 1'b0;
        bus.JamValid = 1'b0;
        chk("rst_run.res_valid", 32'(bus.ResValid),   32'd0);
        chk("rst_run.in_ready",  32'(bus.in_ready),   32'd1);
        chk("rst_run.res_min",   32'(bus.ResMinCost), 32'd123);
        check_all("rst_run");

        // Counter: 999 RUN cycles then capture
        for (int k = 0; k < 64; k++) load_word(7'($urandom));
        repeat (999) clk_edge();
        bus.JamMinCost    = 10'(1 + $urandom_range(0, 1000));
        bus.JamMatchCount = 4'($urandom);
        bus.JamValid      = 1'b1;
        clk_edge();
        chk("cnt.value",     32'(bus.AccessCnt), CNT_EN ? 32'd1000 : 32'd0);
        chk("cnt.res_valid", 32'(bus.ResValid),  32'd1);
        repeat (50) clk_edge();
        chk("cnt.frozen",    32'(bus.AccessCnt), CNT_EN ? 32'd1000 : 32'd0);
        check_all("cnt");
        bus.JamValid = 1'b0;

        // RST in the middle of a load
        bus.restart = 1'b1;
        clk_edge();
        bus.restart = 1'b0;
        for (int k = 0; k < 30; k++) load_word(7'($urandom_range(1, 127)));
        RST = 1'b1;
        clk_edge();
        RST = 1'b0;
        bus.W = 3'd0;
        bus.J = 3'd0;
        #1;
        chk("rst_mid.cost00",    32'(bus.Cost),       32'd0);
        chk("rst_mid.res_min",   32'(bus.ResMinCost), 32'd0);
        chk("rst_mid.res_valid", 32'(bus.ResValid),   32'd0);
        chk("rst_mid.in_ready",  32'(bus.in_ready),   32'd1);
        check_all("rst_mid");

        // Randomized rounds against the model
        for (int r = 0; r < 4; r++) begin
            int budget;
            int restarts;
            if (!m_loading) begin
                bus.restart = 1'b1;
                clk_edge();
                bus.restart = 1'b0;
            end
            budget   = 0;
            restarts = 0;
            while (m_loading && budget < 1000) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = 7'($urandom);
                if (restarts < 1 && $urandom_range(0, 60) == 0) begin
                    bus.restart = 1'b1;
                    restarts++;
                end
                bus.W = 3'($urandom);
                bus.J = 3'($urandom);
                #1;
                check_all("rnd.load");
                clk_edge();
                bus.restart = 1'b0;
                budget++;
            end
            bus.in_valid = 1'b0;
            chk("rnd.load_done", 32'(bus.in_ready), 32'd0);
            for (int c = 0; c < 40; c++) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 7'($urandom);
                bus.W = 3'($urandom);
                bus.J = 3'($urandom);
                if (c == 20 + r) begin
                    bus.JamMinCost    = 10'($urandom);
                    bus.JamMatchCount = 4'($urandom);
                    bus.JamValid      = 1'b1;
                end
                if (c == 30) bus.JamMinCost = 10'($urandom);
                #1;
                check_all("rnd.run");
                clk_edge();
            end
            bus.JamValid = 1'b0;
            bus.in_valid = 1'b0;
            check_all("rnd.end");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
